// File: rtl/sap_control_sequencer_if.sv
// Bus-control bundle between the SAP sequencer and the datapath it steers.
// master = sequencer (drives control word, reads IR opcode); slave = datapath.
interface sap_control_sequencer_if;
  logic [3:0] op_code;
  logic       inc;
  logic       pc_out_en;
  logic       low_ld_mar;
  logic       low_mem_out_en;
  logic       low_ld_ir;
  logic       low_ir_out_en;
  logic       low_ld_acc;
  logic       acc_out_en;
  logic       sub_add;
  logic       subadd_out_en;
  logic       low_ld_b_reg;
  logic       low_ld_out_reg;
  logic       low_halt;
  logic [5:0] t_state;

  modport master (
    input  op_code,
    output inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir, low_ir_out_en,
           low_ld_acc, acc_out_en, sub_add, subadd_out_en, low_ld_b_reg,
           low_ld_out_reg, low_halt, t_state
  );

  modport slave (
    output op_code,
    input  inc, pc_out_en, low_ld_mar, low_mem_out_en, low_ld_ir, low_ir_out_en,
           low_ld_acc, acc_out_en, sub_add, subadd_out_en, low_ld_b_reg,
           low_ld_out_reg, low_halt, t_state
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: one-hot T1..T6 ring plus halted flag, decoded into the bus-control word.
// Define SEQ_VAR_LEN_EN to end each instruction right after its last active T-state.
module sap_control_sequencer (
  input  logic                          clk,
  input  logic                          clr,
  sap_control_sequencer_if.master       bus
);
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  typedef struct packed {
    logic inc;
    logic pc_out_en;
    logic low_ld_mar;
    logic low_mem_out_en;
    logic low_ld_ir;
    logic low_ir_out_en;
    logic low_ld_acc;
    logic acc_out_en;
    logic sub_add;
    logic subadd_out_en;
    logic low_ld_b_reg;
    logic low_ld_out_reg;
    logic low_halt;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    inc: 1'b0, pc_out_en: 1'b0, low_ld_mar: 1'b1, low_mem_out_en: 1'b1,
    low_ld_ir: 1'b1, low_ir_out_en: 1'b1, low_ld_acc: 1'b1, acc_out_en: 1'b0,
    sub_add: 1'b0, subadd_out_en: 1'b0, low_ld_b_reg: 1'b1, low_ld_out_reg: 1'b1,
    low_halt: 1'b1
  };

  ring_t ring_q, ring_d;
  logic  halted_q, halted_d;
  ctrl_t ctrl;

`ifdef SEQ_VAR_LEN_EN
  logic known_op;
  assign known_op = bus.op_code inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT};
`endif

  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (ring_q)
        T1: ring_d = T2;
        T2: ring_d = T3;
`ifdef SEQ_VAR_LEN_EN
        T3: ring_d = known_op ? T4 : T1;
`else
        T3: ring_d = T4;
`endif
        T4: begin
          if (bus.op_code == OP_HLT) begin
            halted_d = 1'b1;   // ring parks on T4 until clr
            ring_d   = T4;
          end
`ifdef SEQ_VAR_LEN_EN
          else if (bus.op_code == OP_OUT) ring_d = T1;
`endif
          else ring_d = T5;
        end
`ifdef SEQ_VAR_LEN_EN
        T5: ring_d = (bus.op_code == OP_LDA) ? T1 : T6;
`else
        T5: ring_d = T6;
`endif
        T6: ring_d = T1;
        default: ring_d = T1;  // recover from a corrupted ring
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ring_q   <= T1;
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    if (halted_q) begin
      ctrl.low_halt = 1'b0;
    end else begin
      case (ring_q)
        T1: begin
          ctrl.pc_out_en  = 1'b1;
          ctrl.low_ld_mar = 1'b0;
        end
        T2: ctrl.inc = 1'b1;
        T3: begin
          ctrl.low_mem_out_en = 1'b0;
          ctrl.low_ld_ir      = 1'b0;
        end
        T4: begin
          case (bus.op_code)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctrl.low_ir_out_en = 1'b0;
              ctrl.low_ld_mar    = 1'b0;
            end
            OP_OUT: begin
              ctrl.acc_out_en     = 1'b1;
              ctrl.low_ld_out_reg = 1'b0;
            end
            OP_HLT:  ctrl.low_halt = 1'b0;
            default: ;
          endcase
        end
        T5: begin
          case (bus.op_code)
            OP_LDA: begin
              ctrl.low_mem_out_en = 1'b0;
              ctrl.low_ld_acc     = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ctrl.low_mem_out_en = 1'b0;
              ctrl.low_ld_b_reg   = 1'b0;
              ctrl.sub_add        = (bus.op_code == OP_SUB);
            end
            default: ;
          endcase
        end
        T6: begin
          if (bus.op_code == OP_ADD || bus.op_code == OP_SUB) begin
            ctrl.subadd_out_en = 1'b1;
            ctrl.low_ld_acc    = 1'b0;
            ctrl.sub_add       = (bus.op_code == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inc            = ctrl.inc;
  assign bus.pc_out_en      = ctrl.pc_out_en;
  assign bus.low_ld_mar     = ctrl.low_ld_mar;
  assign bus.low_mem_out_en = ctrl.low_mem_out_en;
  assign bus.low_ld_ir      = ctrl.low_ld_ir;
  assign bus.low_ir_out_en  = ctrl.low_ir_out_en;
  assign bus.low_ld_acc     = ctrl.low_ld_acc;
  assign bus.acc_out_en     = ctrl.acc_out_en;
  assign bus.sub_add        = ctrl.sub_add;
  assign bus.subadd_out_en  = ctrl.subadd_out_en;
  assign bus.low_ld_b_reg   = ctrl.low_ld_b_reg;
  assign bus.low_ld_out_reg = ctrl.low_ld_out_reg;
  assign bus.low_halt       = ctrl.low_halt;
  assign bus.t_state        = ring_q;
endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: directed + random opcode streams against a T-step/micro-op table model.
module tb_sap_control_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  sap_control_sequencer_if bus ();
  sap_control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

  // Active-high "asserted" bit positions; LOW_MASK flips active-low ones.
  localparam int INC = 12, PCO = 11, MAR = 10, MEM = 9, IRL = 8, IRO = 7;
  localparam int ACCL = 6, ACCO = 5, SUB = 4, SAO = 3, BL = 2, OUTL = 1, HALT = 0;
  localparam logic [12:0] LOW_MASK = 13'b0_0111_1100_0111;

  int tests = 0;
  int fails = 0;
  int step  = 1;        // model T-step 1..6
  bit halted = 1'b0;

  function automatic logic [12:0] model_word(int s, logic [3:0] op, bit h);
    logic [12:0] a;
    a = '0;
    if (h) a[HALT] = 1'b1;
    else if (s == 1) begin a[PCO] = 1; a[MAR] = 1; end
    else if (s == 2) a[INC] = 1;
    else if (s == 3) begin a[MEM] = 1; a[IRL] = 1; end
    else if (s == 4) begin
      if (op <= 4'h2)      begin a[IRO] = 1; a[MAR] = 1; end
      else if (op == 4'hE) begin a[ACCO] = 1; a[OUTL] = 1; end
      else if (op == 4'hF) a[HALT] = 1;
    end else if (s == 5) begin
      if (op == 4'h0) begin a[MEM] = 1; a[ACCL] = 1; end
      else if (op == 4'h1 || op == 4'h2) begin a[MEM] = 1; a[BL] = 1; a[SUB] = (op == 4'h2); end
    end else if (s == 6) begin
      if (op == 4'h1 || op == 4'h2) begin a[SAO] = 1; a[ACCL] = 1; a[SUB] = (op == 4'h2); end
    end
    return a ^ LOW_MASK;
  endfunction

  function automatic logic [12:0] observed();
    return {bus.inc, bus.pc_out_en, bus.low_ld_mar, bus.low_mem_out_en, bus.low_ld_ir,
            bus.low_ir_out_en, bus.low_ld_acc, bus.acc_out_en, bus.sub_add, bus.subadd_out_en,
            bus.low_ld_b_reg, bus.low_ld_out_reg, bus.low_halt};
  endfunction

  task automatic check_now(string tag);
    logic [5:0]  exp_t;
    logic [12:0] exp_w;
    int drv;
    exp_t = 6'(1 << (step - 1));
    exp_w = model_word(step, bus.op_code, halted);
    tests++;
    assert (bus.t_state === exp_t) else begin
      fails++;
      $error("FAIL %s t_state got %b exp %b", tag, bus.t_state, exp_t);
    end
    tests++;
    assert (observed() === exp_w) else begin
      fails++;
      $error("FAIL %s word got %b exp %b (op %h step %0d)", tag, observed(), exp_w, bus.op_code, step);
    end
    drv = int'(bus.pc_out_en) + int'(!bus.low_mem_out_en) + int'(!bus.low_ir_out_en)
        + int'(bus.acc_out_en) + int'(bus.subadd_out_en);
    tests++;
    assert (drv <= 1) else begin
      fails++;
      $error("FAIL %s bus_drivers got %0d exp <=1", tag, drv);
    end
  endtask

  // One rising edge; model follows the inputs held across it, then sample at negedge.
  task automatic tick();
    @(posedge clk);
    if (clr) begin step = 1; halted = 1'b0; end
    else if (!halted) begin
      if (step == 4 && bus.op_code == 4'hF) halted = 1'b1;
      else step = (step == 6) ? 1 : step + 1;
    end
    @(negedge clk);
  endtask

  // Run one instruction from T1: opcode is noise during fetch, real during execute.
  task automatic run_instr(logic [3:0] op, string tag);
    int n = 0;
    do begin
      bus.op_code = (step <= 3) ? 4'($urandom_range(0, 15)) : op;
      #1 check_now(tag);
      tick();
      n++;
    end while (step != 1 && !halted && n < 8);
    if (halted) begin
      repeat (10) begin
        bus.op_code = 4'($urandom_range(0, 15));
        #1 check_now({tag, "_halted"});
        tick();
      end
      check_now({tag, "_frozen"});
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_now({tag, "_clr"});
    end else begin
      tests++;
      assert (n == 6) else begin
        fails++;
        $error("FAIL %s length got %0d exp 6", tag, n);
      end
    end
  endtask

  initial begin
    bus.op_code = 4'h3;
    clr = 1'b1;
    @(negedge clk);
    tick();
    clr = 1'b0;
    check_now("reset");
    // walk the fetch cycle explicitly, then back to T1 via a full NOP
    tick(); check_now("fetch_t2");
    tick(); check_now("fetch_t3");
    tick(); tick(); tick(); tick();
    check_now("nop_wrap");

    run_instr(4'h0, "lda");
    run_instr(4'h1, "add");
    run_instr(4'h2, "sub");
    run_instr(4'hE, "out");
    run_instr(4'h5, "nop");
    run_instr(4'hF, "hlt");
    for (int op = 0; op < 16; op++) run_instr(4'(op), "sweep");
    for (int i = 0; i < 40; i++) run_instr(4'($urandom_range(0, 15)), "rand");

    // clr mid-instruction
    tick(); tick(); tick();
    bus.op_code = 4'h1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_now("clr_mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
